// File: rtl/led_frame_seq.sv
// Frame sequencer for the 8-strip LED wall: walks the bit-plane RAM, presents one
// vector per LED bit period, then holds a reset gap. Optional macro: FRAME_LOOP_EN.
module led_frame_seq #(
    parameter int unsigned NUM_LEDS = 64,
    parameter int unsigned SLOT_CYC = 25,
    parameter int unsigned RST_CYC  = 10000,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic              clk_in,
    input  logic              ar,
    input  logic              start,
`ifdef FRAME_LOOP_EN
    input  logic              stop,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        sr_data,
    output logic              bit_tick,
    output logic              gap,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BIT_CYC  = 3 * SLOT_CYC;
    localparam int unsigned NUM_BITS = NUM_LEDS * 24;
    localparam int unsigned CNT_MAX  = (BIT_CYC > RST_CYC) ? BIT_CYC : RST_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last;

`ifdef FRAME_LOOP_EN
    logic stop_flag;

    // Sticky stop request, consumed at the end of the current gap
    always_ff @(posedge clk_in or posedge ar) begin
        if (ar) begin
            stop_flag <= 1'b0;
        end else if (state == S_GAP && cnt == CNT_W'(RST_CYC - 1)) begin
            stop_flag <= 1'b0;
        end else if (busy && stop) begin
            stop_flag <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_in or posedge ar) begin
        if (ar) begin
            state    <= S_IDLE;
            cnt      <= '0;
            last     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            sr_data  <= 8'h00;
            bit_tick <= 1'b0;
            gap      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_en    <= 1'b0;
            bit_tick <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start coinciding with done is dropped
                    if (start && !done) begin
                        state   <= S_LOAD;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        cnt     <= CNT_W'(1);
                        last    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // cnt 0 only on a looped restart, where the read is issued here
                    if (cnt == CNT_W'(0)) begin
                        rd_en <= 1'b1;
                        cnt   <= CNT_W'(1);
                    end else if (cnt == CNT_W'(1)) begin
                        cnt <= CNT_W'(2);
                    end else begin
                        sr_data  <= rd_data;
                        bit_tick <= 1'b1;
                        cnt      <= '0;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt == CNT_W'(BIT_CYC - 1)) begin
                        cnt <= '0;
                        if (last) begin
                            state   <= S_GAP;
                            sr_data <= 8'h00;
                            gap     <= 1'b1;
                        end else begin
                            sr_data  <= rd_data;
                            bit_tick <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        // Prefetch so the data lands exactly on the period boundary
                        if (cnt == CNT_W'(BIT_CYC - 3)) begin
                            if (rd_addr == LAST_ADDR) begin
                                last <= 1'b1;
                            end else begin
                                rd_en   <= 1'b1;
                                rd_addr <= rd_addr + ADDR_W'(1);
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (cnt == CNT_W'(RST_CYC - 1)) begin
                        gap  <= 1'b0;
                        done <= 1'b1;
                        cnt  <= '0;
                        last <= 1'b0;
`ifdef FRAME_LOOP_EN
                        if (!(stop_flag || stop)) begin
                            state   <= S_LOAD;
                            rd_addr <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= S_IDLE;
                        busy  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_seq.sv
// Directed bench for led_frame_seq with NUM_LEDS=2, BIT_CYC=6, RST_CYC=20 and RAM[k]=k.
module tb_led_frame_seq;

    localparam int unsigned NUM_LEDS = 2;
    localparam int unsigned SLOT_CYC = 2;
    localparam int unsigned RST_CYC  = 20;
    localparam int unsigned ADDR_W   = 6;
    localparam int BIT_CYC   = 6;
    localparam int NBITS     = 48;
    localparam int FRAME_CYC = 310;
    localparam int GAP_START = 290;

    logic              clk_in = 1'b0;
    logic              ar     = 1'b1;
    logic              start  = 1'b0;
`ifdef FRAME_LOOP_EN
    logic              stop   = 1'b0;
`endif
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data = 8'hEE;
    logic [7:0]        sr_data;
    logic              bit_tick;
    logic              gap;
    logic              busy;
    logic              done;

    int n_assert = 0;
    int n_fail   = 0;

    led_frame_seq #(
        .NUM_LEDS(NUM_LEDS), .SLOT_CYC(SLOT_CYC), .RST_CYC(RST_CYC), .ADDR_W(ADDR_W)
    ) dut (
        .clk_in(clk_in), .ar(ar), .start(start),
`ifdef FRAME_LOOP_EN
        .stop(stop),
`endif
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .sr_data(sr_data),
        .bit_tick(bit_tick), .gap(gap), .busy(busy), .done(done)
    );

    always #5 clk_in = ~clk_in;

    // RAM[k]=k, data present only in the single cycle after a read strobe
    always @(posedge clk_in) begin
        if (rd_en) rd_data <= 8'(rd_addr);
        else       rd_data <= 8'hEE;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        ar = 1'b1;
        start = 1'b0;
        repeat (2) tick();
        n_assert++; if ({rd_en, bit_tick, gap, busy, done} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {rd_en, bit_tick, gap, busy, done}); end
        n_assert++; if (rd_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
        n_assert++; if (sr_data !== 8'h00) begin n_fail++; $display("FAIL reset_sr: got %0d want 0", sr_data); end
        ar = 1'b0;
        repeat (3) tick();
        n_assert++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_frame();
        int n_tick = 0, n_rd = 1, exp_addr = 1, max_addr = 0, n_gap = 0, n_done = 0;
        int err_tick = 0, err_hold = 0, err_addr = 0, err_gap = 0, err_done = 0, err_busy = 0;
        start = 1'b1; tick(); start = 1'b0;
        n_assert++; if (busy !== 1'b1 || rd_en !== 1'b1) begin n_fail++; $display("FAIL frame_accept: busy=%b rd_en=%b want 1 1", busy, rd_en); end
        n_assert++; if (rd_addr !== '0) begin n_fail++; $display("FAIL frame_first_addr: got %0d want 0", rd_addr); end
        for (int t = 1; t <= FRAME_CYC; t++) begin
            tick();
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            if (rd_en) begin
                if (int'(rd_addr) != exp_addr) err_addr++;
                exp_addr++;
                n_rd++;
            end
            if (bit_tick) begin
                if (t != 2 + BIT_CYC * n_tick || sr_data !== 8'(n_tick)) err_tick++;
                n_tick++;
            end else if (t >= 2 && t < GAP_START && sr_data !== 8'(n_tick - 1)) begin
                err_hold++;
            end
            if (t >= GAP_START && t < FRAME_CYC) begin
                if (gap) n_gap++;
                if (sr_data !== 8'h00 || rd_en !== 1'b0 || bit_tick !== 1'b0) err_gap++;
            end else if (gap) begin
                err_gap++;
            end
            if (done) begin
                n_done++;
                if (t != FRAME_CYC) err_done++;
            end
            if (t < FRAME_CYC && busy !== 1'b1) err_busy++;
        end
        n_assert++; if (n_tick != NBITS) begin n_fail++; $display("FAIL frame_tick_count: got %0d want %0d", n_tick, NBITS); end
        n_assert++; if (err_tick != 0) begin n_fail++; $display("FAIL frame_tick_timing_data: got %0d bad ticks want 0", err_tick); end
        n_assert++; if (err_hold != 0) begin n_fail++; $display("FAIL frame_sr_hold: got %0d bad cycles want 0", err_hold); end
        n_assert++; if (n_rd != NBITS) begin n_fail++; $display("FAIL frame_rd_count: got %0d want %0d", n_rd, NBITS); end
        n_assert++; if (err_addr != 0) begin n_fail++; $display("FAIL frame_rd_order: got %0d bad reads want 0", err_addr); end
        n_assert++; if (max_addr != NBITS - 1) begin n_fail++; $display("FAIL frame_max_addr: got %0d want %0d", max_addr, NBITS - 1); end
        n_assert++; if (n_gap != int'(RST_CYC)) begin n_fail++; $display("FAIL gap_length: got %0d want %0d", n_gap, RST_CYC); end
        n_assert++; if (err_gap != 0) begin n_fail++; $display("FAIL gap_outputs: got %0d bad cycles want 0", err_gap); end
        n_assert++; if (n_done != 1 || err_done != 0) begin n_fail++; $display("FAIL frame_done: got %0d pulses (%0d misplaced) want 1 at cycle 310", n_done, err_done); end
        n_assert++; if (err_busy != 0) begin n_fail++; $display("FAIL frame_busy: got %0d low cycles want 0", err_busy); end
        n_assert++; if (busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL frame_end: busy=%b done=%b want 0 1", busy, done); end
        tick();
        n_assert++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL frame_after: busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_ignore();
        int n_done = 0, err_done = 0, err_busy = 0;
        logic exp_busy;
        start = 1'b1; tick(); start = 1'b0;
        for (int t = 1; t <= FRAME_CYC + 2; t++) begin
            start = (t == 10 || t == 300 || t == FRAME_CYC + 1 || t == FRAME_CYC + 2);
            tick();
            if (done) begin
                n_done++;
                if (t != FRAME_CYC) err_done++;
            end
            exp_busy = !(t == FRAME_CYC || t == FRAME_CYC + 1);
            if (busy !== exp_busy) err_busy++;
        end
        start = 1'b0;
        n_assert++; if (n_done != 1 || err_done != 0) begin n_fail++; $display("FAIL ignore_done: got %0d pulses (%0d misplaced) want 1 at cycle 310", n_done, err_done); end
        n_assert++; if (err_busy != 0) begin n_fail++; $display("FAIL ignore_busy: got %0d bad cycles want 0", err_busy); end
        n_assert++; if (rd_en !== 1'b1 || rd_addr !== '0) begin n_fail++; $display("FAIL restart_after_done: rd_en=%b rd_addr=%0d want 1 0", rd_en, rd_addr); end
    endtask

    task automatic test_abort();
        int waited = 0;
        int n_bad = 0;
        while (!(bit_tick && sr_data == 8'd5) && waited < 100) begin
            tick();
            waited++;
        end
        n_assert++; if (waited != 32) begin n_fail++; $display("FAIL abort_reach_addr5: got %0d cycles want 32", waited); end
        repeat (2) tick();
        ar = 1'b1;
        #1;
        n_assert++; if ({rd_en, bit_tick, gap, busy, done} !== 5'b0 || sr_data !== 8'h00 || rd_addr !== '0) begin
            n_fail++; $display("FAIL abort_async: flags=%b sr=%0d addr=%0d want 00000 0 0", {rd_en, bit_tick, gap, busy, done}, sr_data, rd_addr);
        end
        tick();
        ar = 1'b0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) n_bad++;
        end
        n_assert++; if (n_bad != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d busy/done cycles want 0", n_bad); end
        start = 1'b1; tick(); start = 1'b0;
        n_assert++; if (rd_en !== 1'b1 || rd_addr !== '0) begin n_fail++; $display("FAIL abort_restart_addr: rd_en=%b rd_addr=%0d want 1 0", rd_en, rd_addr); end
        repeat (2) tick();
        n_assert++; if (bit_tick !== 1'b1 || sr_data !== 8'h00) begin n_fail++; $display("FAIL abort_restart_data: tick=%b sr=%0d want 1 0", bit_tick, sr_data); end
    endtask

`ifdef FRAME_LOOP_EN
    task automatic test_loop();
        int n_done = 0, err_done = 0, err_busy = 0, n_tick = 0;
        logic exp_busy;
        ar = 1'b1; tick(); ar = 1'b0; tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int t = 1; t <= 660; t++) begin
            stop = (t == 400);
            tick();
            if (bit_tick) n_tick++;
            if (done) begin
                n_done++;
                if (t != FRAME_CYC && t != 621) err_done++;
            end
            exp_busy = (t < 621);
            if (busy !== exp_busy) err_busy++;
            if (t == FRAME_CYC + 1) begin
                n_assert++; if (rd_en !== 1'b1 || rd_addr !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL loop_restart: rd_en=%b addr=%0d busy=%b want 1 0 1", rd_en, rd_addr, busy); end
            end
        end
        stop = 1'b0;
        n_assert++; if (n_done != 2 || err_done != 0) begin n_fail++; $display("FAIL loop_done: got %0d pulses (%0d misplaced) want 2", n_done, err_done); end
        n_assert++; if (err_busy != 0) begin n_fail++; $display("FAIL loop_busy: got %0d bad cycles want 0", err_busy); end
        n_assert++; if (n_tick != 2 * NBITS) begin n_fail++; $display("FAIL loop_ticks: got %0d want %0d", n_tick, 2 * NBITS); end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_frame();
        test_ignore();
        test_abort();
`ifdef FRAME_LOOP_EN
        test_loop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
